// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: sequences start, serializer data, optional parity and stop bits.
// The serializer supplies the data bits; this block owns framing, parity and timing-fault detection.
module uart_tx_ctrl #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] P_DATA,
  input  logic              DATA_VALID,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  input  logic              ser_data,
  input  logic              ser_done,
  output logic              ser_en,
  output logic [DATA_W-1:0] ser_p_data,
  output logic              TX_OUT,
  output logic              Busy,
  output logic              ser_err
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] data_cnt;
  logic             par_en_q;
  logic             par_typ_q;
  logic             par_bit_q;

  logic accept_c;
  logic last_c;
  logic data_exit_c;
  logic fault_c;

  assign accept_c    = DATA_VALID && ((state == IDLE) || (state == STOP));
  assign last_c      = (data_cnt == CNT_W'(DATA_W));
  assign data_exit_c = (state == DATA) && (ser_done || last_c);
  // ser_done must coincide with the last data cycle; early or missing is a fault
  assign fault_c     = (state == DATA) && (ser_done != last_c);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_c) state_nxt = START;
      START:   state_nxt = DATA;
      DATA:    if (data_exit_c) state_nxt = par_en_q ? PARITY : STOP;
      PARITY:  state_nxt = STOP;
      STOP:    state_nxt = accept_c ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    TX_OUT = 1'b1;
    ser_en = 1'b0;
    Busy   = 1'b0;
    case (state)
      START: begin
        TX_OUT = 1'b0;
        ser_en = 1'b1;
        Busy   = 1'b1;
      end
      DATA: begin
        TX_OUT = ser_data;
        ser_en = 1'b1;
        Busy   = 1'b1;
      end
      PARITY: begin
        TX_OUT = par_bit_q;
        Busy   = 1'b1;
      end
      STOP: begin
        Busy   = 1'b1;
      end
      default: begin
        TX_OUT = 1'b1;
        ser_en = 1'b0;
        Busy   = 1'b0;
      end
    endcase
  end

  // Request latching, parity computed from the latched byte during START
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ser_p_data <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_bit_q  <= 1'b0;
    end else begin
      if (accept_c) begin
        ser_p_data <= P_DATA;
        par_en_q   <= PAR_EN;
        par_typ_q  <= PAR_TYP;
      end
      if (state == START) begin
        par_bit_q <= (^ser_p_data) ^ par_typ_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_cnt <= '0;
      ser_err  <= 1'b0;
    end else begin
      ser_err <= fault_c;
      if (state == START) begin
        data_cnt <= CNT_W'(1);
      end else if ((state == DATA) && !data_exit_c) begin
        data_cnt <= data_cnt + CNT_W'(1);
      end else begin
        data_cnt <= '0;
      end
    end
  end

endmodule
